// File: rtl/vvp_acc.sv
// Bit-plane shift-accumulator for the vvp partial-sum stream: weights each beat by
// its plane/digit significance. Optional mode generation: define VVPACC_MODE_GEN_EN.
module vvp_acc #(
    parameter int N     = 64,
    parameter int WPREC = 2,
    parameter int DPREC = 2,
    localparam int IW   = $clog2(N) + 2,
    localparam int OW   = IW + WPREC + 2 * DPREC - 1,
    localparam int NB   = WPREC * DPREC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] in_s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
`ifdef VVPACC_MODE_GEN_EN
    output logic [1:0]           mode_o,
`endif
    output logic                 state_o
);

    localparam int PW = (WPREC > 1) ? $clog2(WPREC) : 1;
    localparam int DW = (DPREC > 1) ? $clog2(DPREC) : 1;
    localparam int SW = $clog2(OW) + 1;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // valid never depends on ready, and out_data is stable while out_valid & ~out_ready.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         plane_q, plane_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic signed [OW-1:0]  acc_q, acc_d;
    logic signed [OW-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic                  accept;
    logic                  last_plane;
    logic                  last_digit;
    logic [SW-1:0]         shift;
    logic signed [OW-1:0]  ext;
    logic signed [OW-1:0]  term;
    logic signed [OW-1:0]  sum;

    // Beat k is tracked as (plane, digit) so the shift i + 2*j needs no divider.
    assign last_plane = (plane_q == PW'(WPREC - 1));
    assign last_digit = (digit_q == DW'(DPREC - 1));
    assign shift      = SW'(plane_q) + SW'({digit_q, 1'b0});
    assign ext        = {{(OW - IW){in_s[IW-1]}}, in_s};
    assign term       = ext <<< shift;
    assign sum        = acc_q + term;

    assign in_ready  = (state_q == ACCUM) & ~clr;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign state_o   = state_q;

`ifdef VVPACC_MODE_GEN_EN
    // The weight MSB plane is the two's-complement sign plane when WPREC > 1.
    assign mode_o = ((state_q == ACCUM) && (WPREC > 1) && last_plane) ? 2'b11 : 2'b01;
`endif

    always_comb begin
        state_d     = state_q;
        plane_d     = plane_q;
        digit_d     = digit_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: begin
                if (clr) begin
                    acc_d   = '0;
                    plane_d = '0;
                    digit_d = '0;
                end else if (accept) begin
                    if (last_plane && last_digit) begin
                        out_data_d  = sum;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                        acc_d       = '0;
                        plane_d     = '0;
                        digit_d     = '0;
                    end else begin
                        acc_d = sum;
                        if (last_plane) begin
                            plane_d = '0;
                            digit_d = digit_q + DW'(1);
                        end else begin
                            plane_d = plane_q + PW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                // clr drops the held result even when the consumer is ready.
                if (clr || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d     = ACCUM;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            plane_q     <= '0;
            digit_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            plane_q     <= plane_d;
            digit_q     <= digit_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_vvp_acc.sv
// Bench for vvp_acc: default build (WPREC=DPREC=2) plus an NB==1 instance, checked
// against a transaction-level model (beat list -> weighted sum).
module tb_vvp_acc;

    localparam int N = 64, WPREC = 2, DPREC = 2;
    localparam int IW = 8, OW = 13, NB = 4;
    localparam int OW1 = 10;

    logic clk = 1'b0;
    logic rst, clr, in_valid, out_ready, in_ready, out_valid, state_o;
    logic signed [IW-1:0] in_s;
    logic signed [OW-1:0] out_data;
    logic in_valid1, out_ready1, in_ready1, out_valid1, state1;
    logic signed [IW-1:0] in_s1;
    logic signed [OW1-1:0] out_data1;
`ifdef VVPACC_MODE_GEN_EN
    logic [1:0] mode_o, mode1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int     m_beats[$];
    bit     m_hold;
    longint m_out;
    bit     h1;
    longint out1;

    always #5 clk = ~clk;

    vvp_acc #(.N(N), .WPREC(WPREC), .DPREC(DPREC)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef VVPACC_MODE_GEN_EN
        .mode_o(mode_o),
`endif
        .state_o(state_o)
    );

    vvp_acc #(.N(N), .WPREC(1), .DPREC(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_s(in_s1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
`ifdef VVPACC_MODE_GEN_EN
        .mode_o(mode1),
`endif
        .state_o(state1)
    );

    function automatic longint weigh(input int q[$]);
        longint s = 0;
        for (int k = 0; k < q.size(); k++)
            s += longint'(q[k]) * (longint'(1) << ((k % WPREC) + 2 * (k / WPREC)));
        return s;
    endfunction

    function automatic logic [1:0] exp_mode();
        if (m_hold) return 2'b01;
        return ((WPREC > 1) && ((m_beats.size() % WPREC) == WPREC - 1)) ? 2'b11 : 2'b01;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock.
    task automatic cycle();
        if (rst) begin
            m_beats.delete(); m_hold = 0; m_out = 0; h1 = 0; out1 = 0;
        end else begin
            if (clr) begin
                m_beats.delete(); m_hold = 0;
            end else if (m_hold) begin
                if (out_ready) m_hold = 0;
            end else if (in_valid) begin
                m_beats.push_back(int'(in_s));
                if (m_beats.size() == NB) begin
                    m_out = weigh(m_beats); m_hold = 1; m_beats.delete();
                end
            end
            if (clr) h1 = 0;
            else if (h1) begin
                if (out_ready1) h1 = 0;
            end else if (in_valid1) begin
                out1 = longint'(in_s1); h1 = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; clr = 0; in_valid = 0; out_ready = 0; in_s = '0;
        in_valid1 = 0; out_ready1 = 0; in_s1 = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        cycle(); cycle();
        rst = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (state_o !== 1'b0) begin errors++; $display("FAIL reset_state got %0b exp 0", state_o); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got %0b exp 0", out_valid1); end
`ifdef VVPACC_MODE_GEN_EN
        checks++; if (mode_o !== 2'b01) begin errors++; $display("FAIL reset_mode got %0b exp 01", mode_o); end
`endif
    endtask

    // One full operand, optional stall in HOLD, then the output handshake.
    task automatic run_operand(input int v[4], input int stall, input longint exp_c, input string name);
        logic signed [OW-1:0] held;
        for (int b = 0; b < NB; b++) begin
            in_valid = 1; in_s = IW'(v[b]); out_ready = 0;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready beat %0d got %0b exp 1", name, b, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid beat %0d got %0b exp 0", name, b, out_valid); end
`ifdef VVPACC_MODE_GEN_EN
            checks++; if (mode_o !== exp_mode()) begin errors++; $display("FAIL %s_mode beat %0d got %0b exp %0b", name, b, mode_o, exp_mode()); end
`endif
            cycle();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency got %0b exp 1", name, out_valid); end
        checks++; if (longint'(out_data) !== exp_c) begin errors++; $display("FAIL %s_result got %0d exp %0d", name, out_data, exp_c); end
        checks++; if (longint'(out_data) !== m_out) begin errors++; $display("FAIL %s_model got %0d exp %0d", name, out_data, m_out); end
        held = out_data;
        for (int c = 0; c < stall; c++) begin
            in_valid = 1; in_s = IW'($urandom);
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_hold_ready got %0b exp 0", name, in_ready); end
`ifdef VVPACC_MODE_GEN_EN
            checks++; if (mode_o !== 2'b01) begin errors++; $display("FAIL %s_hold_mode got %0b exp 01", name, mode_o); end
`endif
            cycle();
            checks++; if (out_data !== held || out_valid !== 1'b1) begin errors++; $display("FAIL %s_hold_stable got %0d/%0b exp %0d/1", name, out_data, out_valid, held); end
        end
        in_valid = 1; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_handshake_ready got %0b exp 0", name, in_ready); end
        cycle();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_fall got %0b exp 0", name, out_valid); end
        checks++; if (out_data !== held) begin errors++; $display("FAIL %s_data_kept got %0d exp %0d", name, out_data, held); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_next_ready got %0b exp 1", name, in_ready); end
        in_valid = 0;
    endtask

    task automatic test_basic();
        run_operand('{1, 1, 1, 1}, 0, 15, "ones");
        run_operand('{-128, -128, -128, -128}, 0, -1920, "minneg");
        run_operand('{127, 0, 0, 127}, 3, 1143, "stall");
    endtask

    task automatic test_back_to_back();
        int v[4];
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < NB; b++) v[b] = int'($signed(IW'($urandom)));
            run_operand(v, 0, weigh('{v[0], v[1], v[2], v[3]}), "b2b");
        end
    endtask

    task automatic test_clr_accum();
        in_valid = 1; in_s = 8'sd5; cycle();
        in_s = 8'sd3; cycle();
        clr = 1; in_s = 8'sd99;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %0b exp 0", in_ready); end
        cycle();
        clr = 0; in_valid = 0;
        run_operand('{1, 1, 1, 1}, 0, 15, "after_clr");
    endtask

    task automatic test_clr_hold();
        for (int b = 0; b < NB; b++) begin
            in_valid = 1; in_s = IW'($urandom); cycle();
        end
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || longint'(out_data) !== m_out) begin errors++; $display("FAIL clr_hold_pre got %0d/%0b exp %0d/1", out_data, out_valid, m_out); end
        clr = 1; out_ready = 1;
        cycle();
        clr = 0; out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_hold_valid got %0b exp 0", out_valid); end
        checks++; if (state_o !== 1'b0) begin errors++; $display("FAIL clr_hold_state got %0b exp 0", state_o); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_hold_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_rst_mid();
        in_valid = 1; in_s = 8'sd7; cycle(); cycle();
        rst = 1; cycle();
        rst = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rst_mid_out got %0d/%0b exp 0/0", out_data, out_valid); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %0b exp 1", in_ready); end
        run_operand('{1, 1, 1, 1}, 1, 15, "after_rst");
    endtask

    task automatic test_random();
        int results = 0;
        for (int t = 0; t < 600; t++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_s       = IW'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            clr        = ($urandom_range(0, 40) == 0);
            in_valid1  = $urandom_range(0, 1);
            in_s1      = IW'($urandom);
            out_ready1 = $urandom_range(0, 1);
            #1;
            checks++; if (in_ready !== (!m_hold && !clr)) begin errors++; $display("FAIL rnd_in_ready t=%0d got %0b exp %0b", t, in_ready, !m_hold && !clr); end
            checks++; if (in_ready1 !== (!h1 && !clr)) begin errors++; $display("FAIL rnd_in_ready1 t=%0d got %0b exp %0b", t, in_ready1, !h1 && !clr); end
`ifdef VVPACC_MODE_GEN_EN
            checks++; if (mode_o !== exp_mode()) begin errors++; $display("FAIL rnd_mode t=%0d got %0b exp %0b", t, mode_o, exp_mode()); end
            checks++; if (mode1 !== 2'b01) begin errors++; $display("FAIL rnd_mode1 t=%0d got %0b exp 01", t, mode1); end
`endif
            cycle();
            checks++; if (out_valid !== m_hold) begin errors++; $display("FAIL rnd_out_valid t=%0d got %0b exp %0b", t, out_valid, m_hold); end
            if (m_hold) begin
                checks++; if (longint'(out_data) !== m_out) begin errors++; $display("FAIL rnd_out_data t=%0d got %0d exp %0d", t, out_data, m_out); end
                results++;
            end
            checks++; if (out_valid1 !== h1) begin errors++; $display("FAIL rnd_out_valid1 t=%0d got %0b exp %0b", t, out_valid1, h1); end
            if (h1) begin
                checks++; if (longint'(out_data1) !== out1) begin errors++; $display("FAIL rnd_out_data1 t=%0d got %0d exp %0d", t, out_data1, out1); end
            end
        end
        idle();
        checks++; if (results == 0) begin errors++; $display("FAIL rnd_no_results got 0 exp >0"); end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_back_to_back();
        test_clr_accum();
        test_clr_hold();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
